bcd_updown_counter: RTL
=======================

Name: bcd_updown_counter

Overview:
- Two-digit BCD up/down counter; the device under test that the team's clock/reset stimulus drives and monitors.
- Provides:
  - a programmable modulus
  - synchronous load with a valid/ready handshake
  - a one-cycle terminal-count pulse
  - a 4-bit `count` view of the ones digit, for direct hookup to the existing 4-bit count monitor.

Parameters:
- MODULUS, 100, count range 0..MODULUS-1; legal range 2..100.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable, sampled each rising edge.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load_valid  input  1  load request.
- load_data  input  8  BCD load value: [7:4] tens, [3:0] ones.
- load_ready  output  1  counter can accept a load this cycle.
- load_err  output  1  one-cycle pulse: accepted load value was illegal and was discarded.
- count_bcd  output  8  current value in BCD: [7:4] tens, [3:0] ones.
- count  output  4  ones digit; equals count_bcd[3:0].
- tc  output  1  one-cycle pulse on wrap-around.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- While rst=1, all outputs are forced immediately:
  - count_bcd=8'h00, count=4'h0
  - tc=0, load_err=0
  - load_ready=1
  - FSM in IDLE
- Reset mid-operation, including mid-load, abandons the operation with no residual pulse.
- FSM states:
  - IDLE: en=0, no load.
  - RUN: en=1, counting.
  - LOADACK: one-cycle recovery after an accepted load.
- load_ready is 1 in IDLE and RUN, and 0 in LOADACK.
- Load acceptance:
  - A load is accepted on a rising edge where load_valid=1 and load_ready=1.
  - If load_data is legal BCD (both nibbles ≤9) and its value is < MODULUS:
    - count_bcd = load_data on that edge.
    - tc is not asserted.
  - Otherwise:
    - count_bcd is unchanged.
    - load_err=1 for exactly the next cycle.
  - Either way, the FSM enters LOADACK for one cycle, then goes to RUN if en=1, else IDLE.
- Priority: an accepted load beats counting. When load and en coincide, no count step occurs that cycle.
- No counting in LOADACK, even with en=1.
- load_valid held high while load_ready=0 is ignored until load_ready returns to 1. Sources must keep load_valid/load_data stable until accepted.
- Count step (RUN or IDLE with en=1, no accepted load): latency is one edge; the value changes on the edge that samples en=1.
  - Up:
    - ones 9 → 0 with tens +1; otherwise ones +1.
    - Value MODULUS-1 → 00, and tc=1 for the next cycle.
  - Down:
    - ones 0 → 9 with tens -1; otherwise ones -1.
    - Value 00 → MODULUS-1 (BCD-encoded), and tc=1 for the next cycle.
- Arithmetic is done per BCD digit. No binary intermediate value is exposed, and count_bcd never holds a nibble >9.
- Changing up while en=1 takes effect on the next edge; there is no pipeline.
- en=0: value held; tc=0.
- tc and load_err are registered, never both high, and never high for more than one consecutive cycle unless successive wrap events occur.
- MODULUS=100: wrap points are 99↔00. MODULUS=10: tens digit stays 0.
- count and count_bcd are registered outputs with no combinational path from inputs.

Test Plan:
1. Reset: rst=1 at t=0 with en=1, released at t=20 -> count_bcd=00, load_ready=1 during reset. First rising edge after release gives 01; after 10 enabled edges count_bcd=8'h10, count=0.
2. Up wrap, MODULUS=100: load 8'h98, en=1, up=1 -> LOADACK cycle holds 98; then 99, then 00 with tc=1 for exactly one cycle; then 01 with tc=0.
3. Down wrap, MODULUS=60: load 8'h01, en=1, up=0 -> 00, then 59 (8'h59) with tc=1 for one cycle, then 58.
4. Illegal loads, MODULUS=60: load 8'h3A -> count_bcd unchanged, load_err=1 for one cycle. Then load 8'h75 -> same rejection. Then load 8'h42 -> 42, load_err=0.
5. Priority/handshake: load_valid held high across two cycles with en=1 and load_data=8'h20 -> load accepted once, load_ready=0 for one cycle, no count step in the load cycle or LOADACK, then 21, 22.
6. Async reset mid-count: rst asserted between edges at value 8'h57 -> count_bcd=00 immediately (before the next edge), tc=0, load_err=0.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Two-digit BCD up/down counter with programmable modulus, handshaked
// synchronous load, one-cycle terminal-count pulse and a ones-digit view.
// MODULUS must lie in 2..100; the count range is 0..MODULUS-1.
module bcd_updown_counter #(
    parameter int unsigned MODULUS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic       load_err,
    output logic [7:0] count_bcd,
    output logic [3:0] count,
    output logic       tc
);

    localparam int unsigned MAX_VALUE = MODULUS - 1;
    localparam logic [3:0]  MAX_TENS  = 4'(MAX_VALUE / 10);
    localparam logic [3:0]  MAX_ONES  = 4'(MAX_VALUE % 10);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] LOADACK = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       tc_q, tc_d;
    logic       load_err_q, load_err_d;
    logic       load_ready_q, load_ready_d;

    logic       load_acc;
    logic       load_legal;
    logic       at_max;
    logic       at_zero;
    logic [3:0] ld_tens;
    logic [3:0] ld_ones;

    // Decode of the load request and the current value against the wrap points
    always_comb begin
        ld_tens    = load_data[7:4];
        ld_ones    = load_data[3:0];
        load_acc   = load_valid & load_ready_q;
        // Digit-wise compare keeps the check in BCD: legal digits and value <= MODULUS-1
        load_legal = (ld_tens <= 4'd9) && (ld_ones <= 4'd9) &&
                     ((ld_tens < MAX_TENS) ||
                      ((ld_tens == MAX_TENS) && (ld_ones <= MAX_ONES)));
        at_max     = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
        at_zero    = (tens_q == 4'd0) && (ones_q == 4'd0);
    end

    // Next-state, next-value and pulse generation
    always_comb begin
        state_d    = state_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;

        if (load_acc) begin
            // Accepted load wins over counting; illegal values are discarded
            state_d = LOADACK;
            if (load_legal) begin
                tens_d = ld_tens;
                ones_d = ld_ones;
            end else begin
                load_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                LOADACK: begin
                    // Recovery cycle: no count step regardless of en
                    state_d = en ? RUN : IDLE;
                end
                IDLE, RUN: begin
                    if (en) begin
                        state_d = RUN;
                        if (up) begin
                            if (at_max) begin
                                tens_d = 4'd0;
                                ones_d = 4'd0;
                                tc_d   = 1'b1;
                            end else if (ones_q == 4'd9) begin
                                ones_d = 4'd0;
                                tens_d = tens_q + 4'd1;
                            end else begin
                                ones_d = ones_q + 4'd1;
                            end
                        end else begin
                            if (at_zero) begin
                                tens_d = MAX_TENS;
                                ones_d = MAX_ONES;
                                tc_d   = 1'b1;
                            end else if (ones_q == 4'd0) begin
                                ones_d = 4'd9;
                                tens_d = tens_q - 4'd1;
                            end else begin
                                ones_d = ones_q - 4'd1;
                            end
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        load_ready_d = (state_d != LOADACK);
    end

    // State and output registers; reset abandons any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tens_q       <= 4'd0;
            ones_q       <= 4'd0;
            tc_q         <= 1'b0;
            load_err_q   <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            tc_q         <= tc_d;
            load_err_q   <= load_err_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign count_bcd  = {tens_q, ones_q};
    assign count      = ones_q;
    assign tc         = tc_q;
    assign load_err   = load_err_q;
    assign load_ready = load_ready_q;

endmodule
